// File: rtl/serial_word_tx_pkg.sv
// serial_word_pkg: shared types and constants for the serial word transmitter
// and the downstream shift stage it feeds.
//   state_e         - transmitter FSM states (IDLE, SHIFT, GAP)
//   cnt_width()     - counter width helper, never narrower than 1 bit
//   DEFAULT_WIDTH   - default word length shared with the downstream stage
//   DEFAULT_DIV     - default clock cycles per serial bit
//   PARITY_BITS     - 1 when SERIAL_WORD_TX_PARITY_EN is defined, else 0
//   DS_WIDTH        - width the downstream shift stage must be built with
package serial_word_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } state_e;

  localparam int unsigned DEFAULT_WIDTH = 10;
  localparam int unsigned DEFAULT_DIV   = 1;

`ifdef SERIAL_WORD_TX_PARITY_EN
  localparam int unsigned PARITY_BITS = 1;
`else
  localparam int unsigned PARITY_BITS = 0;
`endif

  localparam int unsigned DS_WIDTH = DEFAULT_WIDTH + PARITY_BITS;

  // Bits needed to hold values 0..n-1, minimum 1.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n < 32'd2) ? 32'd1 : 32'($clog2(n));
  endfunction

endpackage

// File: rtl/serial_word_tx_tick_div.sv
// ser_tick_div: DIV prescaler that produces the serial bit tick.
//   clk, rst_n - clock, async active-low reset
//   clr        - synchronous clear (word handshake)
//   en         - count enable (transmitter shifting)
//   tick_c     - combinational tick, high on the last cycle of each bit period
module ser_tick_div
  import serial_word_pkg::*;
#(
  parameter int unsigned DIV = DEFAULT_DIV
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tick_c
);

  localparam int unsigned CW = cnt_width(DIV + 1);

  logic [CW-1:0] div_cnt;

  assign tick_c = en && (div_cnt == CW'(DIV - 1));

  // Counts 0..DIV-1 while enabled, restarting after each tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
    end else if (clr || tick_c) begin
      div_cnt <= '0;
    end else if (en) begin
      div_cnt <= div_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/serial_word_tx.sv
// serial_word_tx: parallel-to-serial transmitter, MSB first, one bit per strobe.
// Optional macro SERIAL_WORD_TX_PARITY_EN appends an even-parity strobe.
//   clk, rst_n - clock, async active-low reset
//   in_data    - WIDTH-bit word, sampled only on the valid/ready handshake
//   in_valid   - word valid
//   in_ready   - block can accept a word
//   ser_bit    - serial data bit, 0 whenever ser_en is low
//   ser_en     - one-cycle strobe per bit (downstream shift_en)
//   word_done  - pulse coincident with the last strobe of a word
//   busy       - high while shifting or in the inter-word gap
module serial_word_tx
  import serial_word_pkg::*;
#(
  parameter int unsigned WIDTH      = DEFAULT_WIDTH,
  parameter int unsigned DIV        = DEFAULT_DIV,
  parameter int unsigned GAP_CYCLES = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             ser_bit,
  output logic             ser_en,
  output logic             word_done,
  output logic             busy
);

  localparam int unsigned NBITS = WIDTH + PARITY_BITS;
  localparam int unsigned BW    = cnt_width(WIDTH + 2);
  localparam int unsigned GW    = cnt_width(GAP_CYCLES + 1);

  state_e           state;
  logic [NBITS-1:0] shreg;
  logic [BW-1:0]    bit_cnt;
  logic [GW-1:0]    gap_cnt;
  logic [NBITS-1:0] load_c;
  logic             hs_c;
  logic             tick_c;
  logic             last_c;

  // Word as shifted out; parity rides in the LSB so it leaves last.
`ifdef SERIAL_WORD_TX_PARITY_EN
  assign load_c = {in_data, ^in_data};
`else
  assign load_c = in_data;
`endif

  assign hs_c   = (state == ST_IDLE) && in_valid && in_ready;
  assign last_c = (bit_cnt == BW'(NBITS - 1));

  ser_tick_div #(
    .DIV (DIV)
  ) u_tick_div (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (hs_c),
    .en     (state == ST_SHIFT),
    .tick_c (tick_c)
  );

  // Transmit FSM with registered outputs; strobes default low every cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      shreg     <= '0;
      bit_cnt   <= '0;
      gap_cnt   <= '0;
      in_ready  <= 1'b0;
      ser_bit   <= 1'b0;
      ser_en    <= 1'b0;
      word_done <= 1'b0;
      busy      <= 1'b0;
    end else begin
      ser_bit   <= 1'b0;
      ser_en    <= 1'b0;
      word_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          in_ready <= 1'b1;
          busy     <= 1'b0;
          if (hs_c) begin
            shreg    <= load_c;
            bit_cnt  <= '0;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            state    <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (tick_c) begin
            ser_en  <= 1'b1;
            ser_bit <= shreg[NBITS-1];
            shreg   <= {shreg[NBITS-2:0], 1'b0};
            bit_cnt <= bit_cnt + BW'(1);
            if (last_c) begin
              word_done <= 1'b1;
              if (GAP_CYCLES != 0) begin
                gap_cnt <= '0;
                state   <= ST_GAP;
              end else begin
                in_ready <= 1'b1;
                busy     <= 1'b0;
                state    <= ST_IDLE;
              end
            end
          end
        end
        ST_GAP: begin
          if (gap_cnt == GW'(GAP_CYCLES - 1)) begin
            in_ready <= 1'b1;
            busy     <= 1'b0;
            state    <= ST_IDLE;
          end else begin
            gap_cnt <= gap_cnt + GW'(1);
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_word_tx.sv
// Bench for serial_word_tx: three instances (DIV/GAP variants) checked every
// cycle against a timing model plus directed literal checks.
module tb_serial_word_tx;

`ifdef SERIAL_WORD_TX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int NB = 10 + PAR;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid [3];
  logic [9:0] in_data  [3];
  logic       rdy [3];
  logic       sbit[3];
  logic       sen [3];
  logic       wdone[3];
  logic       bsy [3];

  int dv[3] = '{1, 1, 4};
  int gp[3] = '{0, 2, 0};

  always #5 clk = ~clk;

  serial_word_tx #(.WIDTH(10), .DIV(1), .GAP_CYCLES(0)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_data(in_data[0]), .in_valid(in_valid[0]),
    .in_ready(rdy[0]), .ser_bit(sbit[0]), .ser_en(sen[0]),
    .word_done(wdone[0]), .busy(bsy[0]));

  serial_word_tx #(.WIDTH(10), .DIV(1), .GAP_CYCLES(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_data(in_data[1]), .in_valid(in_valid[1]),
    .in_ready(rdy[1]), .ser_bit(sbit[1]), .ser_en(sen[1]),
    .word_done(wdone[1]), .busy(bsy[1]));

  serial_word_tx #(.WIDTH(10), .DIV(4), .GAP_CYCLES(0)) dut_c (
    .clk(clk), .rst_n(rst_n), .in_data(in_data[2]), .in_valid(in_valid[2]),
    .in_ready(rdy[2]), .ser_bit(sbit[2]), .ser_en(sen[2]),
    .word_done(wdone[2]), .busy(bsy[2]));

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input int inst, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40)
        $display("FAIL %s[%0d]: got %0h expected %0h (t=%0t)", nm, inst, act, exp, $time);
    end
  endtask

  function automatic logic [NB-1:0] ext(input logic [9:0] w);
`ifdef SERIAL_WORD_TX_PARITY_EN
    return {w, ^w};
`else
    return w;
`endif
  endfunction

  // Model: word accepted at edge h produces strobe i (1..NB) at edge h+i*DIV,
  // carrying bit NB-i of the extended word; ready again at h+NB*DIV+GAP.
  int             cyc = 0;
  bit             m_act[3];
  int             m_h[3];
  int             m_rdy_at[3];
  logic [NB-1:0]  m_word[3];
  logic           e_rdy[3], e_bit[3], e_en[3], e_done[3], e_busy[3];
  int             hs_n[3];
  int             hs_last[3];
  int             mk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) begin
        m_act[i] = 1'b0; m_rdy_at[i] = 0;
        e_rdy[i] = 1'b0; e_bit[i] = 1'b0; e_en[i] = 1'b0;
        e_done[i] = 1'b0; e_busy[i] = 1'b0;
      end
    end else begin
      cyc++;
      for (int i = 0; i < 3; i++) begin
        if (in_valid[i] && rdy[i]) begin
          hs_n[i]++;
          hs_last[i] = cyc;
        end
        if (in_valid[i] && e_rdy[i]) begin
          m_act[i] = 1'b1;
          m_h[i] = cyc;
          m_word[i] = ext(in_data[i]);
          m_rdy_at[i] = cyc + NB * dv[i] + gp[i];
        end
        mk = cyc - m_h[i];
        e_en[i] = 1'b0; e_bit[i] = 1'b0; e_done[i] = 1'b0;
        if (m_act[i] && mk > 0 && (mk % dv[i]) == 0 && (mk / dv[i]) <= NB) begin
          e_en[i] = 1'b1;
          e_bit[i] = m_word[i][NB - mk / dv[i]];
          e_done[i] = ((mk / dv[i]) == NB);
        end
        e_rdy[i]  = (cyc >= m_rdy_at[i]);
        e_busy[i] = m_act[i] && (cyc < m_rdy_at[i]);
      end
    end
  end

  // Compare process plus downstream shift register and strobe log.
  logic [NB-1:0] ds[3];
  int            st_cnt[3], st_first[3], st_last[3], done_cnt[3], done_cyc[3];
  logic [31:0]   st_bits[3];

  always @(negedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < 3; i++) begin
        chk("in_ready", i, 32'(rdy[i]), 32'(e_rdy[i]));
        chk("ser_en", i, 32'(sen[i]), 32'(e_en[i]));
        chk("ser_bit", i, 32'(sbit[i]), 32'(e_bit[i]));
        chk("word_done", i, 32'(wdone[i]), 32'(e_done[i]));
        chk("busy", i, 32'(bsy[i]), 32'(e_busy[i]));
        if (sen[i]) begin
          ds[i] = {ds[i][NB-2:0], sbit[i]};
          st_cnt[i]++;
          st_bits[i] = {st_bits[i][30:0], sbit[i]};
          if (st_cnt[i] == 1) st_first[i] = cyc;
          st_last[i] = cyc;
        end
        if (wdone[i]) begin
          done_cnt[i]++;
          done_cyc[i] = cyc;
          chk("ds_word", i, 32'(ds[i]), 32'(m_word[i]));
        end
      end
    end
  end

  task automatic clear_log(input int i);
    st_cnt[i] = 0; st_bits[i] = 0; done_cnt[i] = 0;
    st_first[i] = 0; st_last[i] = 0; done_cyc[i] = 0;
  endtask

  task automatic send(input int i, input logic [9:0] w, input bit keep);
    int n0;
    n0 = hs_n[i];
    in_data[i] = w;
    in_valid[i] = 1'b1;
    for (int t = 0; t < 300 && hs_n[i] == n0; t++) begin
      @(negedge clk); #1;
    end
    if (hs_n[i] == n0) chk("hs_timeout", i, 32'd0, 32'd1);
    if (!keep) in_valid[i] = 1'b0;
  endtask

  task automatic all_zero(input string nm);
    for (int i = 0; i < 3; i++)
      chk(nm, i, {27'd0, rdy[i], sbit[i], sen[i], wdone[i], bsy[i]}, 32'd0);
  endtask

  int h0, h1, h2;

  initial begin
    for (int i = 0; i < 3; i++) begin
      in_valid[i] = 1'b1; in_data[i] = 10'h2A5; ds[i] = '0; hs_n[i] = 0;
      clear_log(i);
    end
    // Reset held with valid asserted: everything stays low.
    repeat (3) begin
      @(negedge clk); #1;
      all_zero("reset_outs");
    end
    for (int i = 0; i < 3; i++) in_valid[i] = 1'b0;
    #2 rst_n = 1'b1;
    @(negedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      chk("ready_after_rst", i, 32'(rdy[i]), 32'd1);
      chk("no_strobe_idle", i, 32'(sen[i]), 32'd0);
    end
    repeat (3) @(negedge clk);
    #1;

    // Single word, DIV=1.
    clear_log(0);
    send(0, 10'h2A5, 1'b0);
    h0 = hs_last[0];
    repeat (NB + 3) @(negedge clk);
    #1;
    chk("xfer_cnt", 0, 32'(st_cnt[0]), 32'(NB));
    chk("xfer_first", 0, 32'(st_first[0] - h0), 32'd1);
    chk("xfer_last", 0, 32'(st_last[0] - h0), 32'(NB));
    chk("xfer_bits", 0, st_bits[0], (PAR != 0) ? 32'h54B : 32'h2A5);
    chk("xfer_done_cnt", 0, 32'(done_cnt[0]), 32'd1);
    chk("xfer_done_at", 0, 32'(done_cyc[0] - h0), 32'(NB));
    chk("xfer_ds", 0, 32'(ds[0] >> PAR), 32'h2A5);

    // Streaming with GAP=2, valid held high.
    clear_log(1);
    send(1, 10'h3FF, 1'b1);
    h0 = hs_last[1];
    send(1, 10'h000, 1'b1);
    h1 = hs_last[1];
    send(1, 10'h155, 1'b0);
    h2 = hs_last[1];
    repeat (NB + 5) @(negedge clk);
    #1;
    chk("stream_gap01", 1, 32'(h1 - h0), 32'(NB + 3));
    chk("stream_gap12", 1, 32'(h2 - h1), 32'(NB + 3));
    chk("stream_done_cnt", 1, 32'(done_cnt[1]), 32'd3);
    chk("stream_ds", 1, 32'(ds[1] >> PAR), 32'h155);

    // Prescaler DIV=4, single 1 in the LSB.
    clear_log(2);
    send(2, 10'h001, 1'b0);
    h0 = hs_last[2];
    repeat (4 * NB + 4) @(negedge clk);
    #1;
    chk("div_cnt", 2, 32'(st_cnt[2]), 32'(NB));
    chk("div_first", 2, 32'(st_first[2] - h0), 32'd4);
    chk("div_last", 2, 32'(st_last[2] - h0), 32'(4 * NB));
    chk("div_bits", 2, st_bits[2], (PAR != 0) ? 32'h003 : 32'h001);
    chk("div_done_at", 2, 32'(done_cyc[2] - h0), 32'(4 * NB));

    // Reset after the 5th strobe aborts the word.
    clear_log(0);
    send(0, 10'h2A5, 1'b0);
    for (int t = 0; t < 50 && st_cnt[0] < 5; t++) begin
      @(negedge clk); #1;
    end
    chk("mid_strobes", 0, 32'(st_cnt[0]), 32'd5);
    rst_n = 1'b0;
    #1;
    all_zero("mid_rst_outs");
    repeat (2) @(negedge clk);
    #1;
    all_zero("mid_rst_hold");
    chk("mid_no_done", 0, 32'(done_cnt[0]), 32'd0);
    rst_n = 1'b1;
    clear_log(0);
    @(negedge clk); #1;
    send(0, 10'h155, 1'b0);
    h0 = hs_last[0];
    repeat (NB + 3) @(negedge clk);
    #1;
    chk("after_cnt", 0, 32'(st_cnt[0]), 32'(NB));
    chk("after_bits", 0, st_bits[0], (PAR != 0) ? 32'h2AB : 32'h155);
    chk("after_done_cnt", 0, 32'(done_cnt[0]), 32'd1);
    chk("after_ds", 0, 32'(ds[0] >> PAR), 32'h155);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/serial_word_tx.md
Name: serial_word_tx

Overview:
- Parallel-to-serial transmitter that sits directly upstream of the WIDTH-bit serial-in shift register stage.
- Accepts one WIDTH-bit word per valid/ready handshake and emits it MSB-first, one bit per strobe, on ser_bit/ser_en.
- ser_bit/ser_en connect to the downstream shift stage's data_in[0]/shift_en. After WIDTH strobes the downstream register holds the word unchanged.

Parameters:
- WIDTH, 10, word length in bits; must be >= 2.
- DIV, 1, clock cycles per serial bit; must be >= 1.
- GAP_CYCLES, 0, idle cycles inserted after each word before in_ready reasserts.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- in_data  in  WIDTH  word to transmit.
- in_valid  in  1  in_data valid; must stay high with stable in_data until accepted.
- in_ready  out  1  block can accept a word (registered).
- ser_bit  out  1  serial data bit, meaningful only while ser_en=1; forced 0 otherwise.
- ser_en  out  1  one-cycle strobe per transmitted bit; drives downstream shift_en.
- word_done  out  1  one-cycle pulse coincident with the last data strobe of a word.
- busy  out  1  high in SHIFT and GAP.

Behaviour:
- Reset (async assert, sync deassert at top level):
  - All outputs 0; state IDLE; all counters 0; shift register 0.
  - in_ready rises in the first clk edge after rst_n deasserts.
- States: IDLE, SHIFT, GAP.
- IDLE:
  - in_ready=1.
  - Handshake = in_valid & in_ready at a rising edge.
  - On handshake: capture in_data into shreg, bit_cnt=0, div_cnt=0, in_ready<=0, go to SHIFT.
- SHIFT:
  - div_cnt counts 0..DIV-1.
  - At div_cnt==DIV-1 (registered outputs): ser_en<=1, ser_bit<=shreg[WIDTH-1], shreg shifts left by one, bit_cnt++.
  - Otherwise ser_en<=0, ser_bit<=0.
  - First strobe is high DIV cycles after the handshake edge. Example: DIV=1, handshake at cycle 0, strobes at cycles 1..WIDTH.
  - When bit_cnt reaches WIDTH, word_done pulses with that last strobe. Then go to GAP if GAP_CYCLES>0, else to IDLE.
- GAP: counts GAP_CYCLES cycles with all strobes low, then go to IDLE.
- Throughput: one word per WIDTH*DIV + GAP_CYCLES + 1 cycles; no back-to-back overlap.
- in_valid outside IDLE is ignored; in_data is never sampled outside the handshake.
- Counter widths: bit_cnt is clog2(WIDTH+2) bits; div_cnt is clog2(DIV+1) bits. Neither counter wraps mid-word.
- Reset mid-word: immediate abort, partial word discarded, no word_done, outputs 0. The next accepted word is sent complete.
- DIV=1: ser_en is continuously high for WIDTH cycles.

Optional Feature:
- Macro SERIAL_WORD_TX_PARITY_EN.
- Defined:
  - After the WIDTH data bits, one extra strobe carries even parity (XOR of the captured word).
  - word_done moves to the parity strobe.
  - Word time becomes (WIDTH+1)*DIV.
  - The downstream stage must be instantiated with WIDTH+1.
- Undefined: no parity strobe; timing exactly as above.

Decomposition:
- Package serial_word_pkg holds:
  - state enum (IDLE, SHIFT, GAP);
  - a clog2-based width function;
  - default WIDTH/DIV constants shared with the downstream shift stage.
- One natural sub-module: ser_tick_div. It is the DIV prescaler producing the bit tick, cleared on handshake and on reset.

Test Plan:
- Reset check: hold rst_n=0 with in_valid=1 -> all outputs 0 during reset; in_ready=1 one edge after release; no strobe before a handshake.
- Word transfer, WIDTH=10, DIV=1, GAP=0, word 10'h2A5:
  - ser_bit sequence 1,0,1,0,1,0,0,1,0,1 on cycles 1..10.
  - word_done at cycle 10.
  - Connected downstream shift register reads 10'h2A5.
- Streaming, GAP_CYCLES=2, in_valid held high with 10'h3FF, 10'h000, 10'h155:
  - handshakes exactly 13 cycles apart;
  - three word_done pulses;
  - downstream captures each word correctly.
- Prescaler, DIV=4, word 10'h001: ser_en high every 4th cycle, 10 strobes over 40 cycles; only the 10th bit is 1.
- Mid-word reset: assert rst_n=0 after the 5th strobe of 10'h2A5 -> outputs 0 immediately, no word_done. The next word 10'h155 then transmits intact.
- Parity build, SERIAL_WORD_TX_PARITY_EN defined, word 10'h2A5 (five ones) -> 11 strobes, 11th bit = 1, word_done on strobe 11.
